reg_dump_reader: RTL

//  Debug/readout engine on the register-file read side. On start it walks a window of

---
 rtl/reg_dump_reader.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/reg_dump_reader.sv
// -----------------------------------------------------------------------------
// reg_dump_reader
//
// Purpose:
//   Debug readout engine for a register file.
//   On start it walks a window of register addresses and drives each one onto
//   the file's combinational read port. It captures the read data and streams
//   (addr, data) beats out over a valid/ready interface. Reads are deferred
//   while the file is being written, so a beat never carries half-committed
//   state.
//
// Ports:
//   clk         in   1       rising-edge clock
//   rst         in   1       asynchronous, active-high reset
//   start       in   1       begin a dump (only honoured in IDLE)
//   first_addr  in   ADDR_W  first register of the window, sampled with start
//   count       in   6       registers to read, 0..NREGS (larger values clamp)
//   abort       in   1       synchronous cancel, back to IDLE without done
//   wr_active   in   1       register file write in progress this cycle
//   rd_addr     out  ADDR_W  register file read address
//   rd_data     in   DATA_W  combinational read data for rd_addr
//   out_valid   out  1       beat available
//   out_ready   in   1       consumer accepts beat
//   out_addr    out  ADDR_W  register address of the beat
//   out_data    out  DATA_W  register contents of the beat
//   out_last    out  1       final beat of the dump
//   busy        out  1       high while capturing or presenting
//   done        out  1       one-cycle pulse after the last beat is accepted
//   dbg_state   out  2       current FSM state, for observation only
//
// Output handshake:
//   A beat transfers on a rising edge where out_valid and out_ready are both
//   high. Once out_valid is raised, out_addr, out_data and out_last hold steady
//   until that transfer. out_valid never depends combinationally on out_ready.
// -----------------------------------------------------------------------------
module reg_dump_reader #(
  parameter int NREGS  = 32,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [5:0]        count,
  input  logic              abort,
  input  logic              wr_active,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_PRESENT = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [5:0]        MAX_COUNT = 6'(NREGS);
  localparam logic [ADDR_W-1:0] TOP_ADDR  = ADDR_W'(NREGS - 1);

  state_t      r_state;
  logic [5:0]  r_remaining;

  logic [5:0]        w_count_clamped;
  logic [ADDR_W-1:0] w_next_addr;

  // A window larger than the file would revisit registers, so it is cut down
  // to one full pass.
  assign w_count_clamped = (count > MAX_COUNT) ? MAX_COUNT : count;

  // The explicit wrap keeps the walk correct when NREGS is not a power of two.
  assign w_next_addr = (rd_addr == TOP_ADDR) ? '0 : rd_addr + ADDR_W'(1);

  assign dbg_state = r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
      rd_addr     <= '0;
      out_valid   <= 1'b0;
      out_addr    <= '0;
      out_data    <= '0;
      out_last    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      // done is only ever raised on the transition into S_DONE. It therefore
      // lasts exactly the one cycle spent in that state.
      done <= 1'b0;

      if (abort) begin
        // Cancel beats everything else this cycle, including a pending accept.
        // out_addr and out_data keep their last values.
        r_state   <= S_IDLE;
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              rd_addr     <= first_addr;
              r_remaining <= w_count_clamped;
              if (w_count_clamped == 6'd0) begin
                r_state <= S_DONE;
                done    <= 1'b1;
              end else begin
                r_state <= S_CAPTURE;
                busy    <= 1'b1;
              end
            end
          end

          S_CAPTURE: begin
            // Hold off while a write is in flight. The write may target
            // rd_addr, and the beat must carry the committed value.
            if (!wr_active) begin
              out_data  <= rd_data;
              out_addr  <= rd_addr;
              out_last  <= (r_remaining == 6'd1);
              out_valid <= 1'b1;
              r_state   <= S_PRESENT;
            end
          end

          S_PRESENT: begin
            if (out_ready) begin
              out_valid   <= 1'b0;
              r_remaining <= r_remaining - 6'd1;
              if (out_last) begin
                out_last <= 1'b0;
                busy     <= 1'b0;
                done     <= 1'b1;
                r_state  <= S_DONE;
              end else begin
                rd_addr <= w_next_addr;
                r_state <= S_CAPTURE;
              end
            end
          end

          S_DONE: begin
            r_state <= S_IDLE;
          end

          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
